line_matrix_cfg_master: RTL and testbench



---
 rtl/line_matrix_cfg_pkg.sv | 24 ++
 rtl/line_matrix_shadow.sv | 57 +++++
 rtl/line_matrix_cfg_master.sv | 151 +++++++++++++++
 tb/tb_line_matrix_cfg_master.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_matrix_cfg_pkg.sv
// Shared types and default timing for the line matrix configuration master.
package line_matrix_cfg_pkg;

    localparam int unsigned CNT_W         = 8;
    localparam int unsigned DEF_SETUP_CYC = 2;
    localparam int unsigned DEF_HIGH_CYC  = 2;
    localparam int unsigned DEF_HOLD_CYC  = 2;
    localparam int unsigned DEF_RST_CYC   = 4;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        CLEAR
    } state_t;

    // Truncate a cycle-count parameter to the timing counter width.
    function automatic logic [CNT_W-1:0] cyc(input int unsigned n);
        return n[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/line_matrix_shadow.sv
// Shadow copy of the routes written to the line matrix: in_sel per out_sel,
// with a registered read port. Used only when LINE_MATRIX_SHADOW_EN is defined.
module line_matrix_shadow #(
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned NUM_OUT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_addr,
    input  logic [SEL_W-1:0] wr_data,
    input  logic [SEL_W-1:0] rd_addr,
    output logic [SEL_W-1:0] rd_data,
    output logic             rd_vld
);

    localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W + 1)'(NUM_OUT);

    logic [SEL_W-1:0] mem [NUM_OUT];
    logic [NUM_OUT-1:0] valid;
    logic rd_hit;

    assign rd_hit = ({1'b0, rd_addr} < NUM_OUT_L) && valid[rd_addr];

    // NOTE: the data array has no reset so it can map onto plain RAM; the
    // separately reset valid bits decide whether an entry is visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end else if (rd_hit) begin
            rd_data <= mem[rd_addr];
            rd_vld  <= 1'b1;
        end else begin
            rd_data <= '0;
            rd_vld  <= 1'b0;
        end
    end

endmodule

// File: rtl/line_matrix_cfg_master.sv
// Serial-configuration initiator for the GPO line matrix (setup/strobe/hold,
// reset pulses). Define LINE_MATRIX_SHADOW_EN to add the shadow read-back table.
module line_matrix_cfg_master
    import line_matrix_cfg_pkg::*;
#(
    parameter int unsigned SEL_W     = 4,
    parameter int unsigned NUM_OUT   = 10,
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned HIGH_CYC  = DEF_HIGH_CYC,
    parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
    parameter int unsigned RST_CYC   = DEF_RST_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_clear,
    input  logic [SEL_W-1:0] cmd_in_sel,
    input  logic [SEL_W-1:0] cmd_out_sel,
    output logic             busy,
    output logic             cmd_err,
    output logic [15:0]      wr_count,
`ifdef LINE_MATRIX_SHADOW_EN
    input  logic [SEL_W-1:0] shadow_rd_addr,
    output logic [SEL_W-1:0] shadow_rd_data,
    output logic             shadow_rd_vld,
`endif
    output logic             lm_clk,
    output logic             lm_rstn,
    output logic [SEL_W-1:0] lm_input_select,
    output logic [SEL_W-1:0] lm_output_select
);

    localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W + 1)'(NUM_OUT);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_done;
    logic             accept;
    logic             out_legal;

    // Handshake decodes only the registered state; no path from cmd_valid.
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign cnt_done  = (cnt == CNT_W'(1));
    assign out_legal = ({1'b0, cmd_out_sel} < NUM_OUT_L);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= INIT;
            cnt              <= cyc(RST_CYC);
            cmd_err          <= 1'b0;
            wr_count         <= '0;
            lm_clk           <= 1'b0;
            lm_rstn          <= 1'b0;
            lm_input_select  <= '0;
            lm_output_select <= '0;
        end else begin
            cmd_err <= 1'b0;
            case (state)
                INIT, CLEAR: begin
                    if (cnt_done) begin
                        state   <= IDLE;
                        lm_rstn <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (cmd_clear) begin
                            state    <= CLEAR;
                            cnt      <= cyc(RST_CYC);
                            lm_rstn  <= 1'b0;
                            wr_count <= '0;
                        end else if (!out_legal) begin
                            cmd_err <= 1'b1;
                        end else begin
                            lm_input_select  <= cmd_in_sel;
                            lm_output_select <= cmd_out_sel;
                            state            <= SETUP;
                            cnt              <= cyc(SETUP_CYC);
                        end
                    end
                end
                SETUP: begin
                    if (cnt_done) begin
                        state  <= STROBE;
                        cnt    <= cyc(HIGH_CYC);
                        lm_clk <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                STROBE: begin
                    if (cnt_done) begin
                        state  <= HOLD;
                        cnt    <= cyc(HOLD_CYC);
                        lm_clk <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt_done) begin
                        state <= IDLE;
                        if (wr_count != 16'hFFFF) begin
                            wr_count <= wr_count + 16'd1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= INIT;
                    cnt     <= cyc(RST_CYC);
                    lm_clk  <= 1'b0;
                    lm_rstn <= 1'b0;
                end
            endcase
        end
    end

`ifdef LINE_MATRIX_SHADOW_EN
    logic shadow_wr;
    logic shadow_clr;

    // Record the route at the same moment it is counted as written.
    assign shadow_wr  = (state == HOLD) && cnt_done;
    assign shadow_clr = accept && cmd_clear;

    line_matrix_shadow #(
        .SEL_W   (SEL_W),
        .NUM_OUT (NUM_OUT)
    ) u_shadow (
        .clk     (clk),
        .rst     (rst),
        .clr     (shadow_clr),
        .wr_en   (shadow_wr),
        .wr_addr (lm_output_select),
        .wr_data (lm_input_select),
        .rd_addr (shadow_rd_addr),
        .rd_data (shadow_rd_data),
        .rd_vld  (shadow_rd_vld)
    );
`else
    // No shadow table in this build.
`endif

endmodule

// File: tb/tb_line_matrix_cfg_master.sv
// Self-checking bench for line_matrix_cfg_master: vector table, scoreboard of
// matrix-side events, and hand sequences for timing, back-to-back and reset.
module tb_line_matrix_cfg_master;

    localparam int NUM_OUT = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_clear = 1'b0;
    logic [3:0]  cmd_in_sel = '0;
    logic [3:0]  cmd_out_sel = '0;
    logic        cmd_ready;
    logic        busy;
    logic        cmd_err;
    logic [15:0] wr_count;
    logic        lm_clk;
    logic        lm_rstn;
    logic [3:0]  lm_input_select;
    logic [3:0]  lm_output_select;
`ifdef LINE_MATRIX_SHADOW_EN
    logic [3:0]  shadow_rd_addr = '0;
    logic [3:0]  shadow_rd_data;
    logic        shadow_rd_vld;
`endif

    line_matrix_cfg_master dut (
        .clk              (clk),
        .rst              (rst),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_clear        (cmd_clear),
        .cmd_in_sel       (cmd_in_sel),
        .cmd_out_sel      (cmd_out_sel),
        .busy             (busy),
        .cmd_err          (cmd_err),
        .wr_count         (wr_count),
`ifdef LINE_MATRIX_SHADOW_EN
        .shadow_rd_addr   (shadow_rd_addr),
        .shadow_rd_data   (shadow_rd_data),
        .shadow_rd_vld    (shadow_rd_vld),
`endif
        .lm_clk           (lm_clk),
        .lm_rstn          (lm_rstn),
        .lm_input_select  (lm_input_select),
        .lm_output_select (lm_output_select)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_ROUTE, EV_ERR, EV_CLEAR} ev_e;
    typedef struct {
        ev_e        kind;
        logic [3:0] in_sel;
        logic [3:0] out_sel;
    } exp_t;
    typedef struct {
        logic        clear;
        logic [3:0]  in_sel;
        logic [3:0]  out_sel;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   strobe_cnt = 0;
    int   err_cnt = 0;
    bit   mon_en = 1'b0;
    logic prev_clk = 1'b0;
    logic prev_rstn = 1'b0;
    logic prev_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input ev_e kind);
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got event %0d want none", kind);
        end else begin
            e = exp_q.pop_front();
            check("sb_kind", kind, e.kind);
            if (kind == EV_ROUTE) begin
                check("sb_in_sel", 32'(lm_input_select), 32'(e.in_sel));
                check("sb_out_sel", 32'(lm_output_select), 32'(e.out_sel));
            end
        end
    endtask

    // Matrix-side monitor: strobe rising edges, error pulses, clear pulses.
    always @(negedge clk) begin
        if (mon_en) begin
            if (lm_clk && !prev_clk) begin
                strobe_cnt++;
                pop_check(EV_ROUTE);
            end
            if (cmd_err) begin
                err_cnt++;
                if (!prev_err) pop_check(EV_ERR);
            end
            if (!lm_rstn && prev_rstn) pop_check(EV_CLEAR);
        end
        prev_clk  = lm_clk;
        prev_rstn = lm_rstn;
        prev_err  = cmd_err;
    end

    // Called at a negedge; returns 1 time unit after the accepting posedge.
    task automatic send(input logic clr, input logic [3:0] i, input logic [3:0] o);
        int   n = 0;
        exp_t e;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(cmd_ready), 1);
        cmd_valid   = 1'b1;
        cmd_clear   = clr;
        cmd_in_sel  = i;
        cmd_out_sel = o;
        if (clr) e.kind = EV_CLEAR;
        else if ({1'b0, o} >= 5'(NUM_OUT)) e.kind = EV_ERR;
        else e.kind = EV_ROUTE;
        e.in_sel  = i;
        e.out_sel = o;
        exp_q.push_back(e);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cmd_clear = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("wait_idle", 32'(cmd_ready), 1);
    endtask

    // Called at a negedge with the DUT in reset: releases it and times INIT.
    task automatic release_reset();
        int n = 0;
        rst = 1'b0;
        while (!lm_rstn && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("init_rstn_len", n, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t       vecs[7];
        logic [3:0] m_in;
        logic [3:0] m_out;
        int         s0;
        int         e0;
        bit         route;

        vecs[0] = '{clear: 1'b0, in_sel: 4'd9,  out_sel: 4'd9,  exp_err: 1'b0, exp_cnt: 16'd2};
        vecs[1] = '{clear: 1'b0, in_sel: 4'd5,  out_sel: 4'd12, exp_err: 1'b1, exp_cnt: 16'd2};
        vecs[2] = '{clear: 1'b0, in_sel: 4'd0,  out_sel: 4'd10, exp_err: 1'b1, exp_cnt: 16'd2};
        vecs[3] = '{clear: 1'b0, in_sel: 4'd15, out_sel: 4'd0,  exp_err: 1'b0, exp_cnt: 16'd3};
        vecs[4] = '{clear: 1'b1, in_sel: 4'd7,  out_sel: 4'd15, exp_err: 1'b0, exp_cnt: 16'd0};
        vecs[5] = '{clear: 1'b0, in_sel: 4'd6,  out_sel: 4'd3,  exp_err: 1'b0, exp_cnt: 16'd1};
        vecs[6] = '{clear: 1'b0, in_sel: 4'd6,  out_sel: 4'd15, exp_err: 1'b1, exp_cnt: 16'd1};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(cmd_ready), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_err", 32'(cmd_err), 0);
        check("rst_count", 32'(wr_count), 0);
        check("rst_lm_clk", 32'(lm_clk), 0);
        check("rst_lm_rstn", 32'(lm_rstn), 0);
        release_reset();
        check("init_ready", 32'(cmd_ready), 1);
        check("init_busy", 32'(busy), 0);
        check("init_in_sel", 32'(lm_input_select), 0);
        check("init_out_sel", 32'(lm_output_select), 0);
        mon_en = 1'b1;

        // Route 3/7 with cycle-exact timing.
        send(1'b0, 4'd3, 4'd7);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("route_lm_clk_k%0d", k), 32'(lm_clk), 32'(k == 3 || k == 4));
            check($sformatf("route_ready_k%0d", k), 32'(cmd_ready), 32'(k == 7));
            if (k == 1) begin
                check("route_in_sel", 32'(lm_input_select), 3);
                check("route_out_sel", 32'(lm_output_select), 7);
            end
            if (k == 6) check("route_count_pre", 32'(wr_count), 0);
            if (k == 7) check("route_count", 32'(wr_count), 1);
        end
        m_in  = 4'd3;
        m_out = 4'd7;

        // Vector table: legal/illegal boundaries, clear with junk selects.
        for (int i = 0; i < 7; i++) begin
            s0 = strobe_cnt;
            e0 = err_cnt;
            route = !vecs[i].clear && ({1'b0, vecs[i].out_sel} < 5'(NUM_OUT));
            send(vecs[i].clear, vecs[i].in_sel, vecs[i].out_sel);
            wait_idle();
            if (route) begin
                m_in  = vecs[i].in_sel;
                m_out = vecs[i].out_sel;
            end
            check($sformatf("vec%0d_count", i), 32'(wr_count), 32'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_errs", i), err_cnt - e0, 32'(vecs[i].exp_err));
            check($sformatf("vec%0d_strobes", i), strobe_cnt - s0, 32'(route));
            check($sformatf("vec%0d_in_sel", i), 32'(lm_input_select), 32'(m_in));
            check($sformatf("vec%0d_out_sel", i), 32'(lm_output_select), 32'(m_out));
            check($sformatf("vec%0d_rstn", i), 32'(lm_rstn), 1);
        end

        // Back-to-back with cmd_valid held high.
        s0 = strobe_cnt;
        send(1'b0, 4'd1, 4'd4);
        cmd_valid   = 1'b1;
        cmd_in_sel  = 4'd2;
        cmd_out_sel = 4'd5;
        exp_q.push_back('{kind: EV_ROUTE, in_sel: 4'd2, out_sel: 4'd5});
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k == 1) check("b2b_first_out_sel", 32'(lm_output_select), 4);
            if (k == 6) check("b2b_ready_k6", 32'(cmd_ready), 0);
            if (k == 7) check("b2b_ready_k7", 32'(cmd_ready), 1);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_ready", 32'(cmd_ready), 0);
        check("b2b_second_in_sel", 32'(lm_input_select), 2);
        check("b2b_second_out_sel", 32'(lm_output_select), 5);
        wait_idle();
        check("b2b_strobes", strobe_cnt - s0, 2);
        check("b2b_count", 32'(wr_count), 3);

        // Reset asserted while lm_clk is high.
        send(1'b0, 4'd8, 4'd1);
        begin
            int n = 0;
            while (!lm_clk && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        check("mid_strobe_seen", 32'(lm_clk), 1);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_lm_clk", 32'(lm_clk), 0);
        check("mid_rst_lm_rstn", 32'(lm_rstn), 0);
        check("mid_rst_count", 32'(wr_count), 0);
        check("mid_rst_busy", 32'(busy), 1);
        check("mid_rst_out_sel", 32'(lm_output_select), 0);
        release_reset();
        exp_q.delete();
        mon_en = 1'b1;
        send(1'b0, 4'd2, 4'd9);
        wait_idle();
        check("post_rst_count", 32'(wr_count), 1);
        check("post_rst_in_sel", 32'(lm_input_select), 2);

`ifdef LINE_MATRIX_SHADOW_EN
        send(1'b0, 4'd5, 4'd2);
        wait_idle();
        shadow_rd_addr = 4'd2;
        @(negedge clk);
        check("shadow_a2_data", 32'(shadow_rd_data), 5);
        check("shadow_a2_vld", 32'(shadow_rd_vld), 1);
        shadow_rd_addr = 4'd9;
        @(negedge clk);
        check("shadow_a9_data", 32'(shadow_rd_data), 2);
        shadow_rd_addr = 4'd12;
        @(negedge clk);
        check("shadow_oob_data", 32'(shadow_rd_data), 0);
        check("shadow_oob_vld", 32'(shadow_rd_vld), 0);
        send(1'b1, 4'd0, 4'd0);
        wait_idle();
        shadow_rd_addr = 4'd2;
        @(negedge clk);
        check("shadow_clr_vld", 32'(shadow_rd_vld), 0);
`endif

        check("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
